river_crossing_ctrl: RTL
========================

# river_crossing_ctrl

Sequencing controller for the farmer/cabbage/goat/wolf river-crossing datapath. Accepts one boat-move request at a time and holds the boat busy for a fixed crossing time. Updates the 4-bit bank-position vector {F,C,G,W}, evaluates the unsafe-bank alarm, and tracks the game result (play, won, lost) and the move count. It sits between the board's pushbutton/switch front end and the LED/7-segment display logic.

## Interface
- CROSS_CYCLES, 4, clock cycles the boat spends in transit per move; legal range 1..255.
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; returns block to start position.
- move_valid  input  1  single-cycle move request strobe.
- move_sel  input  2  passenger: 00 farmer alone, 01 cabbage, 10 goat, 11 wolf.
- restart  input  1  synchronous new-game request; same effect as reset.
- undo  input  1  revert last move from LOST (active only with RIVER_UNDO_EN).
- pos  output  4  {F,C,G,W} bank bits, 0 = start bank, 1 = far bank.
- busy  output  1  high while boat in transit or result being evaluated.
- alarm  output  1  combinational unsafe flag from pos.
- illegal  output  1  one-cycle pulse: rejected move request.
- won  output  1  sticky win flag.
- lost  output  1  sticky loss flag.
- move_count  output  8  completed crossings, saturates at 255.

## Operation
- Single clock, clk; reset is synchronous and active-high.
- Alarm is 1 exactly when {F,C,G,W} is 0011, 0110, 0111, 1000, 1001, 1100, 1011, 1110, 0001... no: exactly 0011, 0110, 0111, 1000, 1001, 1100. In words: the goat is on a bank without the farmer and shares it with the wolf or the cabbage. Alarm is 0 for all other codes.
- FSM states: PLAY, CROSS, EVAL, WON, LOST.
- PLAY: accept move_valid.
  - Legal move: move_sel = 00, or the selected passenger's bit equals F.
  - Legal move: latch move_sel, load transit timer with CROSS_CYCLES-1, go to CROSS.
  - Illegal move: assert illegal the next cycle, stay in PLAY, pos unchanged.
- CROSS: the timer decrements each cycle. At timer = 0, toggle F and the selected passenger bit, increment move_count (saturating), and go to EVAL.
- EVAL: one cycle.
  - alarm = 1: go to LOST.
  - Otherwise, pos = 1111: go to WON.
  - Otherwise: go to PLAY.
- WON and LOST are terminal until restart or reset. LOST may also exit via undo when RIVER_UNDO_EN is defined.
- move_valid outside PLAY is ignored; no illegal pulse is generated.
- restart and reset take priority over all other inputs in every state, including mid-crossing. The crossing is abandoned and no count increment occurs.
- Reset and restart values: state PLAY, pos 0000, move_count 0, busy 0, illegal 0, won 0, lost 0. alarm follows pos, so it is 0.

## Timing
- Request sampled at edge k:
  - busy high from k until edge k+CROSS_CYCLES+1.
  - pos and move_count update at edge k+CROSS_CYCLES.
  - won/lost or return to PLAY at edge k+CROSS_CYCLES+1.
- With CROSS_CYCLES=1, pos updates one edge after acceptance.
- Back-to-back moves: the earliest next accepted request is sampled at edge k+CROSS_CYCLES+1.
- illegal is registered: it pulses high for exactly one cycle following the rejected request edge.
- won and lost are registered state decodes. busy = state is CROSS or EVAL.
- move_count at 255 holds 255 on further crossings.

## Configuration
- RIVER_UNDO_EN defined:
  - A one-deep history register captures pos and move_count before each position update.
  - In LOST, undo (sampled high) restores both values and returns to PLAY, with lost cleared, next edge.
  - undo in any other state is ignored. restart overrides undo.
- RIVER_UNDO_EN undefined:
  - No history register is built and undo is ignored.
  - LOST is exited only by restart or reset.

## Test plan
- Reset, CROSS_CYCLES=4 -> pos 0000, move_count 0, busy/illegal/won/lost/alarm all 0. busy rises the edge after the first legal request and falls 5 edges after acceptance.
- Moves G, F, W, G, C, F, G -> pos sequence 1010, 0010, 1011, 0001, 1101, 0101, 1111. Final result: won=1, move_count=7, alarm never 1.
- From 0000, move farmer alone (00) -> pos 1000, alarm=1, lost=1 one edge later. Further move_valid is ignored and move_count stays 1.
- After G (pos 1010), request cabbage (01) -> illegal pulses one cycle, pos stays 1010, move_count 1.
- restart asserted two cycles into CROSS -> next edge pos 0000, move_count 0, busy 0, state PLAY. No late position update.
- RIVER_UNDO_EN defined: lose at 1000, assert undo -> pos 0000, move_count 0, lost 0, PLAY. Undefined: same stimulus -> lost stays 1.

Source files
------------

// File: rtl/river_crossing_ctrl.sv
// Boat-move sequencer for the farmer/cabbage/goat/wolf puzzle: bank positions, alarm, result and move count.
// Optional build macro: RIVER_UNDO_EN adds a one-deep history so a losing move can be undone.
module river_crossing_ctrl #(
  parameter int unsigned CROSS_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_valid,
  input  logic [1:0] move_sel,
  input  logic       restart,
  input  logic       undo,
  output logic [3:0] pos,
  output logic       busy,
  output logic       alarm,
  output logic       illegal,
  output logic       won,
  output logic       lost,
  output logic [7:0] move_count
);

  localparam int unsigned TIMER_W = 8;
  localparam int unsigned COUNT_W = 8;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(CROSS_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

  typedef enum logic [2:0] {
    PLAY  = 3'd0,
    CROSS = 3'd1,
    EVAL  = 3'd2,
    WON   = 3'd3,
    LOST  = 3'd4
  } state_t;

  state_t               state;
  logic [1:0]           sel_q;
  logic [TIMER_W-1:0]   timer;
  logic                 legal_c;
  logic [3:0]           flip_c;

  // Passenger bit index is ~move_sel: cabbage->2, goat->1, wolf->0.
  assign legal_c = (move_sel == 2'b00) || (pos[~move_sel] == pos[3]);

  always_comb begin
    flip_c = 4'b1000;
    case (sel_q)
      2'b01:   flip_c = 4'b1100;
      2'b10:   flip_c = 4'b1010;
      2'b11:   flip_c = 4'b1001;
      default: flip_c = 4'b1000;
    endcase
  end

  // Goat left without the farmer alongside the wolf or the cabbage.
  assign alarm = (pos[1] != pos[3]) && ((pos[1] == pos[0]) || (pos[1] == pos[2]));

  assign busy = (state == CROSS) || (state == EVAL);
  assign won  = (state == WON);
  assign lost = (state == LOST);

`ifdef RIVER_UNDO_EN
  logic [3:0]         hist_pos;
  logic [COUNT_W-1:0] hist_count;
`else
  logic undo_unused;
  assign undo_unused = undo;
`endif

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state      <= PLAY;
      sel_q      <= 2'b00;
      timer      <= '0;
      pos        <= 4'b0000;
      move_count <= '0;
      illegal    <= 1'b0;
`ifdef RIVER_UNDO_EN
      hist_pos   <= 4'b0000;
      hist_count <= '0;
`endif
    end else begin
      illegal <= 1'b0;
      case (state)
        PLAY: begin
          if (move_valid) begin
            if (legal_c) begin
              sel_q <= move_sel;
              timer <= TIMER_LOAD;
              state <= CROSS;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        CROSS: begin
          if (timer == '0) begin
            pos <= pos ^ flip_c;
            if (move_count != COUNT_MAX) begin
              move_count <= move_count + COUNT_W'(1);
            end
`ifdef RIVER_UNDO_EN
            hist_pos   <= pos;
            hist_count <= move_count;
`endif
            state <= EVAL;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        EVAL: begin
          if (alarm) begin
            state <= LOST;
          end else if (pos == 4'b1111) begin
            state <= WON;
          end else begin
            state <= PLAY;
          end
        end
        WON: begin
          state <= WON;
        end
        LOST: begin
`ifdef RIVER_UNDO_EN
          if (undo) begin
            pos        <= hist_pos;
            move_count <= hist_count;
            state      <= PLAY;
          end
`endif
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

endmodule
